// File: rtl/pdm_decimator.sv
// pdm_decimator: second-order CIC decimator turning a 1-bit PDM stream into signed 8-bit PCM.
// Optional macro PDM_DECIM_CLIP_EN adds clip_out, flagging samples altered by saturation.
`default_nettype none

module pdm_decimator #(
    parameter int DECIM = 64,
    parameter int SYNC  = 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              tick_in,
    input  logic              pdm_in,
    output logic signed [7:0] sample_out,
    output logic              sample_valid_out
`ifdef PDM_DECIM_CLIP_EN
    ,
    output logic              clip_out
`endif
);

    localparam int LOG2  = $clog2(DECIM);
    localparam int W     = 2 * LOG2 + 2;
    localparam int SHIFT = 2 * LOG2 - 7;
    localparam logic signed [W:0] C_MAX = (W+1)'(127);
    localparam logic signed [W:0] C_MIN = -(W+1)'(128);

    logic              pdm_s;
    logic [W-1:0]      x_w;
    logic [W-1:0]      i1_q, i1_d, i2_q, i2_d;
    logic [W-1:0]      d1_q, d2_q, c2_q, c1_w;
    logic [LOG2-1:0]   cnt_q;
    logic [1:0]        warm_q;
    logic              dec_q, comb_vld_q, wrap_w;
    logic signed [W:0] ext_w, y_w;
    logic signed [7:0] sat_w, sample_q;
    logic              clip_w, clip_q, valid_q;

    generate
        if (SYNC != 0) begin : g_sync
            logic [1:0] sync_q;
            always_ff @(posedge clk_in) begin
                if (rst_in) sync_q <= 2'b00;
                else        sync_q <= {sync_q[0], pdm_in};
            end
            assign pdm_s = sync_q[1];
        end else begin : g_nosync
            assign pdm_s = pdm_in;
        end
    endgenerate

    // +1 / -1 in W-bit two's complement; integrators wrap freely
    assign x_w    = pdm_s ? W'(1) : {W{1'b1}};
    assign i1_d   = i1_q + x_w;
    assign i2_d   = i2_q + i1_d;
    assign wrap_w = tick_in && (cnt_q == LOG2'(DECIM - 1));
    assign c1_w   = i2_q - d1_q;
    assign ext_w  = $signed({c2_q[W-1], c2_q});

    generate
        if (SHIFT >= 0) begin : g_shr
            assign y_w = ext_w >>> SHIFT;
        end else begin : g_shl
            assign y_w = ext_w <<< (-SHIFT);
        end
    endgenerate

    always_comb begin
        sat_w  = y_w[7:0];
        clip_w = 1'b0;
        if (y_w > C_MAX) begin
            sat_w  = 8'sd127;
            clip_w = 1'b1;
        end else if (y_w < C_MIN) begin
            sat_w  = -8'sd128;
            clip_w = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            i1_q       <= '0;
            i2_q       <= '0;
            d1_q       <= '0;
            d2_q       <= '0;
            c2_q       <= '0;
            cnt_q      <= '0;
            warm_q     <= '0;
            dec_q      <= 1'b0;
            comb_vld_q <= 1'b0;
            sample_q   <= '0;
            clip_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            dec_q      <= 1'b0;
            comb_vld_q <= 1'b0;
            valid_q    <= comb_vld_q;
            clip_q     <= 1'b0;
            if (tick_in) begin
                i1_q  <= i1_d;
                i2_q  <= i2_d;
                cnt_q <= cnt_q + LOG2'(1);
                dec_q <= wrap_w;
            end
            // Comb stage sees I2 including the wrapping tick; first two results are warm-up
            if (dec_q) begin
                d1_q <= i2_q;
                d2_q <= c1_w;
                c2_q <= c1_w - d2_q;
                if (warm_q == 2'd2) comb_vld_q <= 1'b1;
                else                warm_q     <= warm_q + 2'd1;
            end
            if (comb_vld_q) begin
                sample_q <= sat_w;
                clip_q   <= clip_w;
            end
        end
    end

    assign sample_out       = sample_q;
    assign sample_valid_out = valid_q;
`ifdef PDM_DECIM_CLIP_EN
    assign clip_out = clip_q;
`else
    logic unused_clip_w;
    assign unused_clip_w = clip_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pdm_decimator.sv
// tb_pdm_decimator: scoreboard bench; a direct triangular-FIR reference predicts every PCM sample.
`default_nettype none

module tb_pdm_decimator;

    localparam int DECIM = 64;
    localparam int SYNC  = 1;
    localparam int SHIFT = 5;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic              tick_in = 1'b0;
    logic              pdm_in = 1'b0;
    logic signed [7:0] sample_out;
    logic              sample_valid_out;
`ifdef PDM_DECIM_CLIP_EN
    logic              clip_out;
`endif

    pdm_decimator #(.DECIM(DECIM), .SYNC(SYNC)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .tick_in          (tick_in),
        .pdm_in           (pdm_in),
        .sample_out       (sample_out),
        .sample_valid_out (sample_valid_out)
`ifdef PDM_DECIM_CLIP_EN
        ,
        .clip_out         (clip_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int val;
        int clip;
        int due;
    } exp_t;

    exp_t sb_q[$];
    int   hist[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    int   exp_hold = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: CIC2 at a decimation point equals a triangular FIR over the last 2*DECIM-1 inputs
    initial begin
        int p1, p2, b, mcnt, mres, acc, h, y;
        exp_t e;
        p1 = 0; p2 = 0; mcnt = 0; mres = 0;
        forever begin
            @(posedge clk_in);
            cyc++;
            if (rst_in) begin
                p1 = 0; p2 = 0; mcnt = 0; mres = 0;
                hist.delete();
                sb_q.delete();
                exp_hold = 0;
            end else begin
                b  = (SYNC != 0) ? p2 : int'(pdm_in);
                p2 = p1;
                p1 = int'(pdm_in);
                if (tick_in) begin
                    hist.push_back(b != 0 ? 1 : -1);
                    if (hist.size() > 2 * DECIM - 1) void'(hist.pop_front());
                    if (mcnt == DECIM - 1) begin
                        mcnt = 0;
                        mres++;
                        acc = 0;
                        for (int n = 0; n < hist.size(); n++) begin
                            h = (n < DECIM) ? n + 1 : 2 * DECIM - 1 - n;
                            acc += h * hist[hist.size() - 1 - n];
                        end
                        y = acc >>> SHIFT;
                        e.clip = (y > 127 || y < -128) ? 1 : 0;
                        e.val  = (y > 127) ? 127 : (y < -128) ? -128 : y;
                        e.due  = cyc + 2;
                        if (mres >= 3) sb_q.push_back(e);
                    end else begin
                        mcnt++;
                    end
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (sample_valid_out) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_valid", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("sample", int'(sample_out), e.val);
                    check_eq("latency", cyc, e.due);
`ifdef PDM_DECIM_CLIP_EN
                    check_eq("clip", int'(clip_out), e.clip);
`endif
                    exp_hold = e.val;
                end
            end else begin
                check_eq("hold", int'(sample_out), exp_hold);
`ifdef PDM_DECIM_CLIP_EN
                check_eq("clip_idle", int'(clip_out), 0);
`endif
                if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                    check_eq("missing_valid", 0, 1);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic run_stream(input logic [3:0] pat, input int ntick, input int gap,
                              input int rst_at);
        for (int i = 0; i < ntick; i++) begin
            pdm_in  = pat[i % 4];
            tick_in = 1'b1;
            rst_in  = (i == rst_at);
            @(posedge clk_in);
            #1;
            tick_in = 1'b0;
            rst_in  = 1'b0;
            if (i == rst_at) begin
                check_eq("rst_sample", int'(sample_out), 0);
                check_eq("rst_valid", int'(sample_valid_out), 0);
            end
            repeat (gap - 1) begin
                @(posedge clk_in);
                #1;
            end
        end
    endtask

    task automatic drain_and_check(input string tag, input int steady);
        for (int k = 0; k < 400 && sb_q.size() != 0; k++) @(posedge clk_in);
        #1;
        check_eq("drain_timeout", sb_q.size(), 0);
        check_eq(tag, int'(sample_out), steady);
    endtask

    initial begin
        rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        check_eq("reset_sample", int'(sample_out), 0);
        check_eq("reset_valid", int'(sample_valid_out), 0);
        rst_in = 1'b0;

        run_stream(4'b1111, 6 * DECIM, 4, -1);
        drain_and_check("steady_pos_full", 127);

        run_stream(4'b0000, 6 * DECIM, 4, -1);
        drain_and_check("steady_neg_full", -128);

        run_stream(4'b0101, 6 * DECIM, 4, -1);
        drain_and_check("steady_alt", 0);

        run_stream(4'b0111, 6 * DECIM, 4, -1);
        drain_and_check("steady_75", 64);

        run_stream(4'b0001, 6 * DECIM, 4, -1);
        drain_and_check("steady_25", -64);

        // Reset lands mid-window while a +64 stream is running
        run_stream(4'b0111, 8 * DECIM, 4, 4 * DECIM + 20);
        drain_and_check("steady_after_rst", 64);

        run_stream(4'b0111, 5 * DECIM, 1, -1);
        drain_and_check("steady_tick_every_clk", 64);

        run_stream(4'b0111, 5 * DECIM, 7, -1);
        drain_and_check("steady_tick_every_7", 64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
